// File: rtl/cpu_pkg.sv
// Shared types for the LEGv8 ID/EX stage: control bundle, XZR index and the stall FSM states.
package cpu_pkg;
  localparam int DATA_W  = 64;
  localparam int REG_W   = 5;
  localparam int ALUOP_W = 3;
  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic               mem_to_reg;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX bundle: decoded ID fields and flush in, registered EX fields and stall controls out.
interface id_ex_stage_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_W  = cpu_pkg::REG_W
);
  logic              id_valid;
  logic [REG_W-1:0]  id_rn, id_rm, id_rd;
  logic              id_uses_rm;
  logic [DATA_W-1:0] id_data_a, id_data_b, id_imm;
  ctrl_t             id_ctrl;
  logic              flush;
  logic [REG_W-1:0]  ex_rn, ex_rm, ex_rd;
  logic [DATA_W-1:0] ex_data_a, ex_data_b, ex_imm;
  ctrl_t             ex_ctrl;
  logic              stall_pc, stall_ifid;
  logic [31:0]       stall_count;

  modport master (
    output id_valid, id_rn, id_rm, id_rd, id_uses_rm, id_data_a, id_data_b, id_imm, id_ctrl, flush,
    input  ex_rn, ex_rm, ex_rd, ex_data_a, ex_data_b, ex_imm, ex_ctrl, stall_pc, stall_ifid, stall_count
  );
  modport slave (
    input  id_valid, id_rn, id_rm, id_rd, id_uses_rm, id_data_a, id_data_b, id_imm, id_ctrl, flush,
    output ex_rn, ex_rm, ex_rd, ex_data_a, ex_data_b, ex_imm, ex_ctrl, stall_pc, stall_ifid, stall_count
  );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the load in EX and the instruction sitting in ID.
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rn,
  input  logic [REG_W-1:0] i_id_rm,
  input  logic             i_id_uses_rm,
  output logic             o_lu
);
  localparam logic [REG_W-1:0] L_XZR = '1;

  assign o_lu = i_ex_mem_read && (i_ex_rd != L_XZR) && i_id_valid &&
                ((i_ex_rd == i_id_rn) || (i_id_uses_rm && (i_ex_rd == i_id_rm)));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with one-bubble load-use stall and flush-to-bubble.
// Optional bubble counter enabled by defining STALL_COUNTER_EN.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_W  = cpu_pkg::REG_W
) (
  input  logic          clk,
  input  logic          reset,
  id_ex_stage_if.slave  bus
);
  localparam logic [REG_W-1:0] L_XZR = '1;

  state_t            r_state, w_next;
  logic              w_lu, w_stall, w_bubble;
  logic [REG_W-1:0]  r_rn, r_rm, r_rd;
  logic [DATA_W-1:0] r_data_a, r_data_b, r_imm;
  ctrl_t             r_ctrl;

  load_use_detect #(.REG_W(REG_W)) u_lu (
    .i_ex_mem_read (r_ctrl.mem_read),
    .i_ex_rd       (r_rd),
    .i_id_valid    (bus.id_valid),
    .i_id_rn       (bus.id_rn),
    .i_id_rm       (bus.id_rm),
    .i_id_uses_rm  (bus.id_uses_rm),
    .o_lu          (w_lu)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:     if (!bus.flush && w_lu) w_next = STALL;
      STALL:   w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  // Flush beats a load-use hazard: the dependent instruction is being killed anyway.
  always_comb begin
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.flush)  w_bubble = 1'b1;
        else if (w_lu) begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
        end else        w_bubble = !bus.id_valid;
      end
      STALL:   w_bubble = bus.flush || !bus.id_valid;
      default: w_bubble = 1'b1;
    endcase
  end

  // Reset and bubble share one encoding; index 31 keeps the forwarding unit quiet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rn <= L_XZR; r_rm <= L_XZR; r_rd <= L_XZR;
      r_data_a <= '0; r_data_b <= '0; r_imm <= '0;
      r_ctrl <= '0;
    end else if (w_bubble) begin
      r_rn <= L_XZR; r_rm <= L_XZR; r_rd <= L_XZR;
      r_data_a <= '0; r_data_b <= '0; r_imm <= '0;
      r_ctrl <= '0;
    end else begin
      r_rn <= bus.id_rn; r_rm <= bus.id_rm; r_rd <= bus.id_rd;
      r_data_a <= bus.id_data_a; r_data_b <= bus.id_data_b; r_imm <= bus.id_imm;
      r_ctrl <= bus.id_ctrl;
    end
  end

  assign bus.ex_rn      = r_rn;
  assign bus.ex_rm      = r_rm;
  assign bus.ex_rd      = r_rd;
  assign bus.ex_data_a  = r_data_a;
  assign bus.ex_data_b  = r_data_b;
  assign bus.ex_imm     = r_imm;
  assign bus.ex_ctrl    = r_ctrl;
  assign bus.stall_pc   = w_stall;
  assign bus.stall_ifid = w_stall;

`ifdef STALL_COUNTER_EN
  logic [31:0] r_stall_count;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_stall_count <= '0;
    else if (w_stall) r_stall_count <= r_stall_count + 32'd1;
  end
  assign bus.stall_count = r_stall_count;
`else
  assign bus.stall_count = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios plus random traffic vs a behavioural model.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(64), .REG_W(5)) bus();
  id_ex_stage #(.DATA_W(64), .REG_W(5)) u_dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_chk = 0;
  int n_fail = 0;

  // Model of what EX should hold: a single slot plus a "just stalled" flag.
  logic [4:0]  m_rn, m_rm, m_rd;
  logic [63:0] m_a, m_b, m_imm;
  ctrl_t       m_ctrl;
  bit          m_stalled;
  logic [31:0] m_cnt;

  localparam ctrl_t C_LDUR = '{reg_write:1'b1, mem_read:1'b1, mem_write:1'b0, alu_src:1'b1, mem_to_reg:1'b1, alu_op:3'b000};
  localparam ctrl_t C_ADD  = '{reg_write:1'b1, mem_read:1'b0, mem_write:1'b0, alu_src:1'b0, mem_to_reg:1'b0, alu_op:3'b010};
  localparam ctrl_t C_STUR = '{reg_write:1'b0, mem_read:1'b0, mem_write:1'b1, alu_src:1'b1, mem_to_reg:1'b0, alu_op:3'b000};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_bubble();
    m_rn = 5'd31; m_rm = 5'd31; m_rd = 5'd31;
    m_a = '0; m_b = '0; m_imm = '0; m_ctrl = '0;
  endtask

  task automatic model_reset();
    model_bubble();
    m_stalled = 0;
    m_cnt = '0;
  endtask

  function automatic bit model_hazard();
    if (!m_ctrl.mem_read || m_rd == 5'd31 || !bus.id_valid) return 0;
    return (m_rd == bus.id_rn) || (bus.id_uses_rm && m_rd == bus.id_rm);
  endfunction

  function automatic bit model_stall();
    return !m_stalled && !bus.flush && model_hazard();
  endfunction

  task automatic model_edge();
    bit st;
    st = model_stall();
    if (st) begin
      model_bubble();
      m_stalled = 1;
      m_cnt = m_cnt + 32'd1;
    end else begin
      m_stalled = 0;
      if (bus.flush || !bus.id_valid) model_bubble();
      else begin
        m_rn = bus.id_rn; m_rm = bus.id_rm; m_rd = bus.id_rd;
        m_a = bus.id_data_a; m_b = bus.id_data_b; m_imm = bus.id_imm;
        m_ctrl = bus.id_ctrl;
      end
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef STALL_COUNTER_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_ex();
    chk("ex_rn", 64'(bus.ex_rn), 64'(m_rn));
    chk("ex_rm", 64'(bus.ex_rm), 64'(m_rm));
    chk("ex_rd", 64'(bus.ex_rd), 64'(m_rd));
    chk("ex_data_a", bus.ex_data_a, m_a);
    chk("ex_data_b", bus.ex_data_b, m_b);
    chk("ex_imm", bus.ex_imm, m_imm);
    chk("ex_ctrl", 64'(bus.ex_ctrl), 64'(m_ctrl));
    chk("stall_count", 64'(bus.stall_count), 64'(exp_cnt()));
  endtask

  task automatic drive(input bit v, input int rn, input int rm, input bit urm, input int rd,
                       input ctrl_t c, input bit fl);
    bus.id_valid = v;
    bus.id_rn = 5'(rn); bus.id_rm = 5'(rm); bus.id_rd = 5'(rd);
    bus.id_uses_rm = urm;
    bus.id_data_a = {$urandom, $urandom};
    bus.id_data_b = {$urandom, $urandom};
    bus.id_imm    = {$urandom, $urandom};
    bus.id_ctrl = c;
    bus.flush = fl;
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    #1;
    chk("stall_pc", 64'(bus.stall_pc), 64'(model_stall()));
    chk("stall_ifid", 64'(bus.stall_ifid), 64'(model_stall()));
    @(posedge clk);
    model_edge();
    #1;
    check_ex();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 31, 31, 0, 31, '0, 0);
    model_reset();
    #12;
    // 1: reset state
    chk("rst_ex_rd", 64'(bus.ex_rd), 64'd31);
    chk("rst_ex_rn", 64'(bus.ex_rn), 64'd31);
    chk("rst_ex_ctrl", 64'(bus.ex_ctrl), 64'd0);
    chk("rst_stall_pc", 64'(bus.stall_pc), 64'd0);
    check_ex();
    @(negedge clk);
    reset = 1'b0;

    // 2: LDUR X1 then ADD X2,X1,X3 -> one bubble, then ADD with rn=1
    drive(1, 4, 31, 0, 1, C_LDUR, 0); step();
    drive(1, 1, 3, 1, 2, C_ADD, 0);
    #1 chk("lu_stall_pc", 64'(bus.stall_pc), 64'd1);
    step();
    chk("lu_bubble_ctrl", 64'(bus.ex_ctrl), 64'd0);
    chk("lu_bubble_rd", 64'(bus.ex_rd), 64'd31);
`ifdef STALL_COUNTER_EN
    chk("lu_count", 64'(bus.stall_count), 64'd1);
`endif
    step();
    chk("lu_add_rn", 64'(bus.ex_rn), 64'd1);
    chk("lu_add_ctrl", 64'(bus.ex_ctrl), 64'(C_ADD));

    // 3: load to XZR never stalls
    drive(1, 4, 31, 0, 31, C_LDUR, 0); step();
    drive(1, 31, 31, 1, 2, C_ADD, 0);
    #1 chk("xzr_no_stall", 64'(bus.stall_pc), 64'd0);
    step();
    chk("xzr_add_rd", 64'(bus.ex_rd), 64'd2);

    // 4: hazard plus flush -> bubble, no stall, still RUN
    drive(1, 4, 31, 0, 1, C_LDUR, 0); step();
    drive(1, 1, 3, 1, 2, C_ADD, 1);
    #1 chk("flush_no_stall", 64'(bus.stall_pc), 64'd0);
    step();
    chk("flush_bubble_ctrl", 64'(bus.ex_ctrl), 64'd0);
    drive(1, 5, 6, 1, 7, C_ADD, 0); step();
    chk("flush_then_run_rn", 64'(bus.ex_rn), 64'd5);

    // 5: STUR Rt=X1 behind LDUR X1, with and without uses_rm
    drive(1, 4, 31, 0, 1, C_LDUR, 0); step();
    drive(1, 2, 1, 1, 31, C_STUR, 0);
    #1 chk("stur_stall", 64'(bus.stall_pc), 64'd1);
    step(); step();
    chk("stur_after_rm", 64'(bus.ex_rm), 64'd1);
    drive(1, 4, 31, 0, 1, C_LDUR, 0); step();
    drive(1, 2, 1, 0, 31, C_STUR, 0);
    #1 chk("stur_norm_nostall", 64'(bus.stall_pc), 64'd0);
    step();
    chk("stur_norm_ctrl", 64'(bus.ex_ctrl), 64'(C_STUR));

    // 6: reset asserted while stalling drops stall outputs without a clock
    drive(1, 4, 31, 0, 1, C_LDUR, 0); step();
    drive(1, 1, 3, 1, 2, C_ADD, 0);
    #1 chk("pre_rst_stall", 64'(bus.stall_pc), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_stall_pc", 64'(bus.stall_pc), 64'd0);
    chk("midrst_stall_ifid", 64'(bus.stall_ifid), 64'd0);
    chk("midrst_ex_rd", 64'(bus.ex_rd), 64'd31);
    model_reset();
    check_ex();
    @(negedge clk);
    reset = 1'b0;

    // Random traffic with a small register pool so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      int pool[4] = '{1, 2, 3, 31};
      ctrl_t c;
      c = ctrl_t'($urandom);
      c.mem_read = ($urandom_range(1, 0) == 1);
      drive($urandom_range(99, 0) < 85, pool[$urandom_range(3, 0)], pool[$urandom_range(3, 0)],
            1'($urandom), pool[$urandom_range(3, 0)], c, $urandom_range(99, 0) < 10);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
